// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the CPU MEM stage and a debug port, sequencing 1-cycle read returns.
// Optional starvation guard for the debug port is enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MAX_CPU_RUN = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_e;
  state_e state_q, state_d;
  logic cpu_elig, dbg_force, cpu_win, dbg_win;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);
  logic [RUN_W-1:0] cnt_q, cnt_d;
  assign dbg_force = cnt_q == RUN_W'(MAX_CPU_RUN);
  assign cnt_d = (!dbg_req_i || dbg_win) ? '0 : cpu_win ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !reset_i ? '0 : cnt_d;
`else
  assign dbg_force = MAX_CPU_RUN < 0;
`endif
  always_ff @(posedge clk_i) state_q <= !reset_i ? IDLE : state_d;
  // In CPU_RD the held cpu_req belongs to the returning load, so it is not eligible again.
  always_comb begin
    cpu_elig     = reset_i && cpu_req_i && state_q != CPU_RD;
    dbg_win      = reset_i && dbg_req_i && (!cpu_elig || dbg_force);
    cpu_win      = cpu_elig && !dbg_win;
    mem_en_o     = cpu_win || dbg_win;
    mem_we_o     = cpu_win ? cpu_we_i : dbg_win && dbg_we_i;
    mem_addr_o   = cpu_win ? cpu_addr_i : dbg_win ? dbg_addr_i : '0;
    mem_wdata_o  = cpu_win ? cpu_wdata_i : dbg_win ? dbg_wdata_i : '0;
    dbg_gnt_o    = dbg_win;
    cpu_stall_o  = cpu_elig && !(cpu_win && cpu_we_i);
    cpu_rdata_o  = (reset_i && state_q == CPU_RD) ? mem_rdata_i : '0;
    dbg_rvalid_o = reset_i && state_q == DBG_RD;
    dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;
    state_d      = (cpu_win && !cpu_we_i) ? CPU_RD : (dbg_win && !dbg_we_i) ? DBG_RD : IDLE;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed plan cases plus random traffic against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int AW = 64, DW = 64, MAX = 8;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_CPU_RUN(MAX)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata));
  function automatic logic [DW-1:0] init_val(int i);
    return (i == 2) ? 64'hDEAD_BEEF : {32'hA5A5_0000 | 32'(i), 32'h1234_5670 | 32'(i)};
  endfunction
  // Memory environment: pipelined, read data one cycle after issue, garbage otherwise.
  logic [DW-1:0] env_mem [8];
  logic [7:0] env_wr = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr[5:3]] <= mem_wdata;
      env_wr[mem_addr[5:3]] <= 1'b1;
    end
    mem_rdata <= (mem_en && !mem_we) ? (env_wr[mem_addr[5:3]] ? env_mem[mem_addr[5:3]] : init_val(int'(mem_addr[5:3]))) : {$urandom, $urandom};
  end
  int checks = 0, failures = 0;
  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Reference model: owner of the read returning this cycle (0 none, 1 CPU, 2 DBG), its data, and the CPU run length.
  logic [DW-1:0] ref_mem [8];
  int ret = 0, run = 0;
  logic [DW-1:0] ret_data = '0;
  logic e_stall, e_gnt;
  logic s_stall, s_gnt, s_rvalid, s_en;
  logic [DW-1:0] s_crd;
  task automatic step();
    logic ce, cg, dg, e_en, e_we, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_crd, e_drd;
    @(negedge clk);
    {ce, cg, dg, e_en, e_we, e_rv, e_stall, e_gnt} = '0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_drd = '0;
    if (reset) begin
      ce = cpu_req && ret != 1;
      dg = dbg_req && (!ce || (GUARD && run == MAX));
      cg = ce && !dg;
      e_en = cg || dg;
      e_we = cg ? cpu_we : dg && dbg_we;
      e_addr = cg ? cpu_addr : dg ? dbg_addr : '0;
      e_wd = cg ? cpu_wdata : dg ? dbg_wdata : '0;
      e_gnt = dg;
      e_stall = cpu_req && ret != 1 && !(cg && cpu_we);
      e_crd = (ret == 1) ? ret_data : '0;
      e_rv = ret == 2;
      e_drd = (ret == 2) ? ret_data : '0;
    end
    check("mem_en", DW'(mem_en), DW'(e_en));
    check("mem_we", DW'(mem_we), DW'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("dbg_gnt", DW'(dbg_gnt), DW'(e_gnt));
    check("cpu_stall", DW'(cpu_stall), DW'(e_stall));
    check("cpu_rdata", cpu_rdata, e_crd);
    check("dbg_rvalid", DW'(dbg_rvalid), DW'(e_rv));
    check("dbg_rdata", dbg_rdata, e_drd);
    {s_stall, s_gnt, s_rvalid, s_en, s_crd} = {cpu_stall, dbg_gnt, dbg_rvalid, mem_en, cpu_rdata};
    if (!reset) begin
      ret = 0; run = 0;
    end else begin
      ret = 0;
      if (e_en && !e_we) begin
        ret = cg ? 1 : 2;
        ret_data = ref_mem[e_addr[5:3]];
      end
      if (e_en && e_we) ref_mem[e_addr[5:3]] = e_wd;
      run = (!dbg_req || dg) ? 0 : cg ? run + 1 : run;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_set(logic req, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic dbg_set(logic req, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask
  initial begin
    int grants;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
    reset = 1'b0;
    cpu_set(1'b1, 1'b0, 64'h10, '0);
    dbg_set(1'b1, 1'b0, 64'h0, '0);
    repeat (3) step();
    check("rst_outs_zero", DW'({s_en, s_gnt, s_stall}), '0);
    reset = 1'b1;
    cpu_set(1'b0, 1'b0, '0, '0);
    dbg_set(1'b0, 1'b0, '0, '0);
    step();
    check("idle_no_en", DW'(s_en), '0);
    cpu_set(1'b1, 1'b0, 64'h10, '0);
    step();
    check("ld_issue_stall", DW'(s_stall), 1);
    step();
    check("ld_data", s_crd, 64'hDEAD_BEEF);
    check("ld_no_reissue", DW'({s_en, s_stall}), '0);
    cpu_set(1'b1, 1'b1, 64'h8, 64'h55);
    dbg_set(1'b1, 1'b0, 64'h0, '0);
    step();
    check("st_no_stall", DW'({s_stall, s_gnt, s_en}), DW'(3'b001));
    cpu_set(1'b0, 1'b0, '0, '0);
    step();
    check("dbg_gnt_after_st", DW'(s_gnt), 1);
    dbg_set(1'b0, 1'b0, '0, '0);
    step();
    check("dbg_rvalid_n2", DW'(s_rvalid), 1);
    cpu_set(1'b1, 1'b0, 64'h18, '0);
    dbg_set(1'b1, 1'b1, 64'h20, 64'hCAFE_F00D);
    step();
    check("ld2_dbg_wait", DW'({s_stall, s_gnt}), DW'(2'b10));
    step();
    check("cpu_rd_dbg_wr", DW'({s_stall, s_gnt}), DW'(2'b01));
    check("cpu_rd_data", s_crd, init_val(3));
    cpu_set(1'b0, 1'b0, '0, '0);
    dbg_set(1'b0, 1'b0, '0, '0);
    step();
    cpu_set(1'b1, 1'b1, 64'h30, 64'h77);
    dbg_set(1'b1, 1'b1, 64'h38, 64'h99);
    grants = 0;
    for (int i = 0; i < 20 && !s_gnt; i++) begin
      step();
      if (s_en && !s_gnt) grants++;
    end
    if (GUARD) begin
      check("starve_grants", DW'(grants), DW'(MAX));
      check("starve_gnt_stall", DW'({s_gnt, s_stall}), DW'(2'b11));
    end else begin
      check("strict_no_gnt", DW'(s_gnt), '0);
      check("strict_grants", DW'(grants), 20);
    end
    cpu_set(1'b0, 1'b0, '0, '0);
    dbg_set(1'b1, 1'b0, 64'h0, '0);
    step();
    check("pre_rst_gnt", DW'(s_gnt), 1);
    dbg_set(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    step();
    check("rst_drop_rv", DW'(s_rvalid), '0);
    reset = 1'b1;
    step();
    check("post_rst_no_rv", DW'(s_rvalid), '0);
    dbg_set(1'b1, 1'b0, 64'h10, '0);
    step();
    dbg_set(1'b0, 1'b0, '0, '0);
    step();
    check("post_rst_dbg_rd", DW'(s_rvalid), 1);
    for (int i = 0; i < 3000; i++) begin
      if (!e_stall) cpu_set($urandom_range(0, 2) != 0, 1'($urandom), AW'($urandom_range(0, 7)) << 3, {$urandom, $urandom});
      if (!dbg_req || e_gnt) dbg_set($urandom_range(0, 2) == 0, 1'($urandom), AW'($urandom_range(0, 7)) << 3, {$urandom, $urandom});
      reset = $urandom_range(0, 59) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter and sequencer for the single data-memory port of the 5-stage RISC-V core. It shares the memory between the pipeline's MEM stage (CPU port) and an external debug/loader port (DBG port) and drives the memory's control, address and data inputs. It sequences the memory's one-cycle read latency and stalls the pipeline while a CPU access is waiting or in flight. It sits between the EX/MEM register outputs and the data memory, and ORs its stall into the existing hazard stall.

## Interface
- ADDR_W, 64, address width (byte address, same as execResultEXMEM)
- DATA_W, 64, data width
- MAX_CPU_RUN, 8, consecutive CPU grants allowed while DBG waits (starvation guard only)

- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state
- cpu_req  in  1  MEM-stage access valid (memReadEXMEM | memWriteEXMEM)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_stall==0 in the return cycle
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- dbg_req  in  1  debug access request, held with fields stable until dbg_gnt
- dbg_we  in  1  1 = write
- dbg_addr  in  ADDR_W  address
- dbg_wdata  in  DATA_W  write data
- dbg_gnt  out  1  one-cycle accept pulse
- dbg_rvalid  out  1  one-cycle read-data pulse
- dbg_rdata  out  DATA_W  read data, valid with dbg_rvalid
- mem_en  out  1  memory access issue
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid exactly one cycle after a read issue

## Operation
- FSM state is the return slot of the previous cycle:
  - IDLE: nothing returns this cycle.
  - CPU_RD: CPU read data returns this cycle.
  - DBG_RD: DBG read data returns this cycle.
- Next state:
  - CPU_RD if a CPU read is issued this cycle.
  - DBG_RD if a DBG read is issued this cycle.
  - IDLE otherwise, which includes every write.
- Memory is pipelined, so one new access can issue in any state, including CPU_RD and DBG_RD.
- CPU eligibility: cpu_req=1 and state≠CPU_RD. In CPU_RD the still-asserted cpu_req belongs to the completing load and must not reissue.
- Arbitration:
  - If only one requester is eligible, it wins.
  - If both are eligible, CPU wins, except as given under Configuration.
- Issue: mem_en=1, and mem_we/addr/wdata are taken from the winner. With no winner: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- dbg_gnt = 1 in the DBG issue cycle.
- cpu_stall = 1 when cpu_req=1 and any of the following holds:
  - the CPU is not granted;
  - the CPU is granted a read (waiting for the return slot).
- cpu_stall = 0 in the CPU_RD cycle, and in a CPU write grant cycle (writes complete in one cycle).
- cpu_rdata = mem_rdata in CPU_RD, else 0.
- dbg_rvalid = 1 in DBG_RD; dbg_rdata = mem_rdata in DBG_RD, else 0.

## Timing
- All outputs are combinational from the FSM state and current inputs. Only the FSM and the starvation counter are registered.
- CPU load, uncontended: issue cycle N (stall=1), data and stall=0 at cycle N+1. The load costs exactly 1 stall cycle.
- CPU store, uncontended: 0 stall cycles.
- DBG read: dbg_gnt at cycle N, dbg_rvalid at N+1. DBG write: dbg_gnt only.
- Back-to-back:
  - A DBG access may issue in the CPU_RD cycle.
  - A CPU access may issue in the DBG_RD cycle.
  - Full throughput is 1 access/cycle.
- While reset==0, all outputs are forced to 0, including cpu_stall and dbg_gnt.
- Reset mid-operation: at the reset edge, state returns to IDLE and the counter goes to 0. An in-flight read is dropped, so no dbg_rvalid and no CPU data are produced for it.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined:
  - A counter increments each cycle the CPU wins while the DBG port is requesting (CPU granted, dbg_req=1).
  - The counter clears on dbg_gnt, or when dbg_req=0.
  - When the counter equals MAX_CPU_RUN, the next contended cycle goes to DBG. The CPU sees cpu_stall=1 for that cycle.
  - Counter width: clog2(MAX_CPU_RUN+1).
- Not defined: strict CPU priority. No counter exists, and DBG can starve indefinitely.

## Test plan
- Reset: hold reset=0 with cpu_req=1 and dbg_req=1 → all outputs 0. After release with no requests → mem_en=0, state IDLE.
- CPU load of addr 0x10, where memory holds 0xDEAD_BEEF → cycle N: mem_en=1, mem_we=0, cpu_stall=1. N+1: cpu_rdata=0xDEADBEEF, cpu_stall=0, and no reissue of 0x10.
- CPU store 0x55 to 0x8, with a simultaneous DBG read of 0x0 → CPU is written at N with no stall; dbg_gnt at N+1; dbg_rvalid at N+2.
- Load in CPU_RD cycle with a DBG write pending → the DBG write issues in the CPU_RD cycle (dbg_gnt=1) while cpu_rdata is returned, giving zero bubbles.
- With DMEM_ARB_STARVE_GUARD_EN and MAX_CPU_RUN=8: continuous cpu_req and dbg_req → 8 CPU grants, then dbg_gnt on the 9th cycle with cpu_stall=1. Without the macro → dbg_gnt is never asserted.
- Assert reset in the cycle after a DBG read issue → no dbg_rvalid is ever seen. After release, a new DBG read completes normally.
